// File: rtl/cache_dm_refill.sv
// Direct-mapped write-through data cache with multi-word line refill.
// Loads allocate whole lines; stores write through and never allocate.
module cache_dm_refill #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int SET_BITS   = 4,
  parameter int WORD_BITS  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_type,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [CNT_WIDTH-1:0]    hit_cnt,
  output logic [CNT_WIDTH-1:0]    miss_cnt
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int SETS     = 1 << SET_BITS;
  localparam int WPL      = 1 << WORD_BITS;
  localparam int IDX_LSB  = WORD_BITS + 2;
  localparam int TAG_LSB  = SET_BITS + WORD_BITS + 2;
  localparam int TAG_BITS = ADDR_WIDTH - TAG_LSB;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            type_q, type_d;
  logic [WORD_BITS-1:0]  k_q, k_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]         mem_be_q, mem_be_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q [SETS];
  logic [TAG_BITS-1:0]   tag_d [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS][WPL];
  logic [DATA_WIDTH-1:0] data_d [SETS][WPL];
  logic [DATA_WIDTH-1:0] buf_q [WPL];
  logic [DATA_WIDTH-1:0] buf_d [WPL];

  logic [TAG_BITS-1:0]   req_tag, cur_tag;
  logic [SET_BITS-1:0]   req_idx, cur_idx;
  logic [WORD_BITS-1:0]  req_word, cur_word;
  logic                  lookup_hit, store_hit, mem_done;
  logic [NB-1:0]         req_be;
  logic [DATA_WIDTH-1:0] req_rep;

  assign req_tag  = req_addr[ADDR_WIDTH-1:TAG_LSB];
  assign req_idx  = req_addr[TAG_LSB-1:IDX_LSB];
  assign req_word = req_addr[IDX_LSB-1:2];
  assign cur_tag  = addr_q[ADDR_WIDTH-1:TAG_LSB];
  assign cur_idx  = addr_q[TAG_LSB-1:IDX_LSB];
  assign cur_word = addr_q[IDX_LSB-1:2];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign store_hit  = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  // memory latency is at least one cycle, so a response never shares
  // the cycle of its own request pulse
  assign mem_done   = mem_rvalid && !mem_req_q;

  function automatic logic [DATA_WIDTH-1:0] lane_sel(
    input logic [DATA_WIDTH-1:0] w,
    input logic [1:0]            t,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] r;
    case (t)
      2'b01:   r = DATA_WIDTH'(w[{off, 3'b000} +: 8]);
      2'b10:   r = DATA_WIDTH'(w[{off[1], 4'b0000} +: 16]);
      default: r = w;
    endcase
    return r;
  endfunction

  // store byte enables and lane-replicated store data
  always_comb begin
    req_be  = '1;
    req_rep = req_wdata;
    case (req_type)
      2'b01: begin
        req_be  = NB'(1) << req_addr[1:0];
        req_rep = {NB{req_wdata[7:0]}};
      end
      2'b10: begin
        req_be  = NB'(3) << {req_addr[1], 1'b0};
        req_rep = {(NB/2){req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_we)           state_d = WRITE;
          else if (!lookup_hit) state_d = REFILL;
        end
      end
      REFILL: if (mem_done && k_q == '1) state_d = RESP;
      WRITE:  if (mem_done) state_d = IDLE;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath, memory port, counters and line array updates
  always_comb begin
    addr_d      = addr_q;
    type_d      = type_q;
    k_d         = k_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    buf_d       = buf_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          type_d = req_type;
          if (req_we) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = req_rep;
            mem_be_d    = req_be;
          end else if (lookup_hit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = lane_sel(data_q[req_idx][req_word],
                                   req_type, req_addr[1:0]);
            if (hit_cnt_q != '1)
              hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
          end else begin
            if (miss_cnt_q != '1)
              miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
            k_d        = '0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {req_addr[ADDR_WIDTH-1:IDX_LSB],
                          {WORD_BITS{1'b0}}, 2'b00};
          end
        end
      end
      REFILL: begin
        if (mem_done) begin
          buf_d[k_q] = mem_rdata;
          if (k_q == '1) begin
            for (int w = 0; w < WPL; w++)
              data_d[cur_idx][w] = (WORD_BITS'(w) == k_q) ?
                                   mem_rdata : buf_q[w];
            tag_d[cur_idx]   = cur_tag;
            valid_d[cur_idx] = 1'b1;
          end else begin
            k_d        = k_q + WORD_BITS'(1);
            mem_req_d  = 1'b1;
            mem_addr_d = {addr_q[ADDR_WIDTH-1:IDX_LSB],
                          k_q + WORD_BITS'(1), 2'b00};
          end
        end
      end
      WRITE: begin
        if (mem_done) begin
          if (store_hit) begin
            for (int b = 0; b < NB; b++)
              if (mem_be_q[b])
                data_d[cur_idx][cur_word][b*8 +: 8] =
                  mem_wdata_q[b*8 +: 8];
          end
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = lane_sel(data_q[cur_idx][cur_word],
                               type_q, addr_q[1:0]);
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // control registers, outputs, counters and valid bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      type_q      <= '0;
      k_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
    end else begin
      addr_q      <= addr_d;
      type_q      <= type_d;
      k_q         <= k_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
    end
  end

  // tag, data and refill buffer storage; qualified by the valid bits
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
    buf_q  <= buf_d;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_dm_refill.sv
// Bench for cache_dm_refill: directed scenarios, random traffic
// against a tag/memory reference model, and counter saturation.
module tb_cache_dm_refill;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_type;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  cache_dm_refill dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // backing memory and transaction log
  logic [31:0] mem [16384];
  int          lat = 1;
  int          rv_cnt = 0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic        p_we;
  logic [15:0] p_addr;
  logic [15:0] q_addr [$];
  logic        q_we [$];
  logic [3:0]  q_be [$];
  logic [31:0] q_wd [$];

  // reference model: line valid/tag per index and counters
  logic [15:0] ref_v;
  logic [7:0]  ref_t [16];
  int          ref_hits, ref_miss;

  always @(negedge clk) begin
    logic [31:0] t;
    mem_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        pend       = 1'b0;
        mem_rvalid = 1'b1;
        if (!p_we) begin
          mem_rdata = mem[p_addr[15:2]];
          rv_cnt++;
        end else begin
          mem_rdata = $urandom;
        end
      end
    end
    if (mem_req) begin
      pend   = 1'b1;
      cnt    = lat;
      p_we   = mem_we;
      p_addr = mem_addr;
      q_addr.push_back(mem_addr);
      q_we.push_back(mem_we);
      q_be.push_back(mem_be);
      q_wd.push_back(mem_wdata);
      if (mem_we) begin
        t = mem[mem_addr[15:2]];
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) t[b*8 +: 8] = mem_wdata[b*8 +: 8];
        mem[mem_addr[15:2]] = t;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    ref_v    = '0;
    ref_hits = 0;
    ref_miss = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_clear();
  endtask

  // one request from a negedge in IDLE through its response
  task automatic do_req(input logic we, input logic [1:0] typ,
                        input logic [15:0] addr, input logic [31:0] wd);
    logic [7:0]  tg;
    logic [3:0]  ix;
    logic [1:0]  off;
    logic        hit, got, rdy1;
    logic [31:0] w, exp_rd, rep;
    logic [3:0]  be;
    int          exp_lat, cyc, n_exp;
    tg  = addr[15:8];
    ix  = addr[7:4];
    off = addr[1:0];
    hit = ref_v[ix] && (ref_t[ix] == tg);
    w   = mem[addr[15:2]];
    case (typ)
      2'b01: begin
        be = 4'b0001 << off;
        rep = {4{wd[7:0]}};
        exp_rd = (w >> (8 * off)) & 32'hFF;
      end
      2'b10: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        rep = {2{wd[15:0]}};
        exp_rd = (w >> (16 * off[1])) & 32'hFFFF;
      end
      default: begin
        be = 4'hF;
        rep = wd;
        exp_rd = w;
      end
    endcase
    if (we) begin
      exp_lat = lat + 2;
      exp_rd  = 0;
      n_exp   = 1;
    end else if (hit) begin
      exp_lat = 1;
      n_exp   = 0;
      if (ref_hits < 65535) ref_hits++;
    end else begin
      exp_lat = 4 * (lat + 1) + 2;
      n_exp   = 4;
      if (ref_miss < 65535) ref_miss++;
      ref_v[ix] = 1'b1;
      ref_t[ix] = tg;
    end
    q_addr.delete(); q_we.delete(); q_be.delete(); q_wd.delete();
    req_valid = 1'b1;
    req_we    = we;
    req_type  = typ;
    req_addr  = addr;
    req_wdata = wd;
    cyc  = 0;
    got  = 1'b0;
    rdy1 = 1'b0;
    while (cyc < 400 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = 1'b0;
        rdy1 = req_ready;
      end
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_seen", got, 1);
    chk("latency", cyc, exp_lat);
    chk("rdata", rsp_rdata, exp_rd);
    chk("ready_busy", rdy1, !we && hit);
    chk("hit_cnt", hit_cnt, ref_hits);
    chk("miss_cnt", miss_cnt, ref_miss);
    chk("txn_count", q_addr.size(), n_exp);
    if (q_addr.size() == n_exp) begin
      for (int k = 0; k < n_exp; k++) begin
        if (we) begin
          chk("wr_addr", q_addr[k], {addr[15:2], 2'b00});
          chk("wr_we", q_we[k], 1);
          chk("wr_be", q_be[k], be);
          chk("wr_data", q_wd[k], rep);
        end else begin
          chk("rd_addr", q_addr[k], {addr[15:4], 2'(k), 2'b00});
          chk("rd_we", q_we[k], 0);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        saw;
    logic [7:0]  tg;
    logic [15:0] a;
    int          n;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_type = 2'b00; req_addr = '0; req_wdata = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    do_reset();

    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);

    lat = 1;
    do_req(1'b0, 2'b00, 16'h0124, 0);
    chk("t1_miss", miss_cnt, 1);
    do_req(1'b0, 2'b00, 16'h0128, 0);
    chk("t1_hit", hit_cnt, 1);

    do_reset();
    do_req(1'b0, 2'b00, 16'h0120, 0);
    do_req(1'b0, 2'b00, 16'h1120, 0);
    do_req(1'b0, 2'b00, 16'h0120, 0);
    chk("t2_miss", miss_cnt, 3);

    do_req(1'b1, 2'b01, 16'h0125, 32'h0000_00AB);
    do_req(1'b0, 2'b00, 16'h0124, 0);
    chk("t3_byte1", rsp_rdata[15:8], 8'hAB);

    do_req(1'b1, 2'b00, 16'h2000, 32'hDEAD_BEEF);
    do_req(1'b0, 2'b00, 16'h2000, 0);
    chk("t4_data", rsp_rdata, 32'hDEAD_BEEF);

    rv_cnt = 0;
    req_valid = 1'b1; req_we = 1'b0;
    req_type = 2'b00; req_addr = 16'h0300;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 50 && rv_cnt < 2; i++) @(negedge clk);
    chk("t5_two_words", rv_cnt >= 2, 1);
    @(negedge clk);
    saw = rsp_valid;
    rst_n = 1'b0;
    @(negedge clk);
    saw |= rsp_valid;
    rst_n = 1'b1;
    ref_clear();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      saw |= rsp_valid;
    end
    chk("t5_no_rsp", saw, 0);
    chk("t5_hit0", hit_cnt, 0);
    chk("t5_miss0", miss_cnt, 0);
    chk("t5_ready", req_ready, 1);
    do_req(1'b0, 2'b00, 16'h0300, 0);

    lat = 3;
    do_req(1'b0, 2'b10, 16'h0126, 0);
    chk("t6_half", rsp_rdata, {16'h0, mem[16'h0124 >> 2][31:16]});

    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(1, 4);
      tg = 8'h01 + 8'h10 * 8'($urandom_range(0, 2));
      a = {tg, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      do_req($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
             a, $urandom);
    end

    lat = 1;
    do_req(1'b0, 2'b00, 16'h0120, 0);
    n = 0;
    req_valid = 1'b1; req_we = 1'b0;
    req_type = 2'b00; req_addr = 16'h0120;
    for (int i = 1; i <= 65600; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    req_valid = 1'b0;
    ref_hits = (ref_hits + 65600 > 65535) ? 65535 : ref_hits + 65600;
    @(negedge clk);
    chk("stream_rsp", n, 65600);
    chk("stream_hit_sat", hit_cnt, ref_hits);
    chk("stream_miss", miss_cnt, ref_miss);
    chk("stream_idle", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
